// File: rtl/pcm_frame_fifo.sv
// Byte-wide PCM sample buffer: CPU writes raw bytes, the PCM rate logic pulls
// assembled stereo frames (two signed 16-bit samples) on request.
module pcm_frame_fifo #(
  parameter int DEPTH_LOG2   = 12,
  parameter int AE_THRESHOLD = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_reset,
  input  logic [7:0]  fifo_wrdata,
  input  logic        fifo_write,
  output logic        fifo_full,
  output logic        fifo_almost_empty,
  output logic        fifo_empty,
  input  logic        mode_stereo,
  input  logic        mode_16bit,
  input  logic        frame_req,
  output logic        frame_valid,
  output logic        underrun,
  output logic [15:0] left_sample,
  output logic [15:0] right_sample
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   AE_COUNT   = (DEPTH_LOG2 + 1)'(AE_THRESHOLD);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [2:0] frame_bytes(input logic stereo, input logic wide);
    case ({stereo, wide})
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  logic [7:0]            mem [DEPTH];
  logic [7:0]            rd_data_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  state_t                state_r;
  logic                  stereo_r;
  logic                  wide_r;
  logic [2:0]            n_r;
  logic [1:0]            k_r;
  logic                  rd_vld_r;
  logic [1:0]            rd_idx_r;
  logic [31:0]           asm_r;

  logic                  wr_accept_s;
  logic                  rd_issue_s;
  logic [2:0]            req_n_s;
  logic                  enough_s;
  logic                  last_s;
  logic [31:0]           asm_s;
  logic [15:0]           left_s;
  logic [15:0]           right_s;

  assign fifo_full         = (count_r == FULL_COUNT);
  assign fifo_empty        = (count_r == CNT_ZERO);
  assign fifo_almost_empty = (count_r < AE_COUNT);

  // Handshake decode: accepted write, issued read, request sizing.
  always_comb begin
    wr_accept_s = fifo_write && !fifo_full && !fifo_reset;
    rd_issue_s  = (state_r == FETCH);
    req_n_s     = frame_bytes(mode_stereo, mode_16bit);
    enough_s    = (count_r >= {{(DEPTH_LOG2 - 2){1'b0}}, req_n_s});
    last_s      = ({1'b0, k_r} == (n_r - 3'd1));
  end

  // Merge the byte returning from RAM this cycle into the assembly word.
  always_comb begin
    asm_s = asm_r;
    if (rd_vld_r) begin
      case (rd_idx_r)
        2'd0:    asm_s[7:0]   = rd_data_r;
        2'd1:    asm_s[15:8]  = rd_data_r;
        2'd2:    asm_s[23:16] = rd_data_r;
        2'd3:    asm_s[31:24] = rd_data_r;
        default: asm_s        = asm_r;
      endcase
    end else begin
      asm_s = asm_r;
    end
  end

  // Expand the assembled bytes into left/right samples (8-bit bytes go to the MSB).
  always_comb begin
    case ({stereo_r, wide_r})
      2'b00: begin
        left_s  = {asm_s[7:0], 8'h00};
        right_s = {asm_s[7:0], 8'h00};
      end
      2'b01: begin
        left_s  = asm_s[15:0];
        right_s = asm_s[15:0];
      end
      2'b10: begin
        left_s  = {asm_s[7:0], 8'h00};
        right_s = {asm_s[15:8], 8'h00};
      end
      2'b11: begin
        left_s  = asm_s[15:0];
        right_s = asm_s[31:16];
      end
      default: begin
        left_s  = 16'h0000;
        right_s = 16'h0000;
      end
    endcase
  end

  // Sample storage with one-cycle registered read.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem[wr_ptr_r] <= fifo_wrdata;
    end
    rd_data_r <= mem[rd_ptr_r];
  end

  // Pointers, occupancy and the frame assembly FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      state_r      <= IDLE;
      stereo_r     <= 1'b0;
      wide_r       <= 1'b0;
      n_r          <= 3'd1;
      k_r          <= 2'd0;
      rd_vld_r     <= 1'b0;
      rd_idx_r     <= 2'd0;
      asm_r        <= 32'h0000_0000;
      frame_valid  <= 1'b0;
      underrun     <= 1'b0;
      left_sample  <= 16'h0000;
      right_sample <= 16'h0000;
    end else if (fifo_reset) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      state_r      <= IDLE;
      k_r          <= 2'd0;
      rd_vld_r     <= 1'b0;
      rd_idx_r     <= 2'd0;
      frame_valid  <= 1'b0;
      underrun     <= 1'b0;
      left_sample  <= 16'h0000;
      right_sample <= 16'h0000;
    end else begin
      frame_valid <= 1'b0;
      underrun    <= 1'b0;
      rd_vld_r    <= rd_issue_s;
      rd_idx_r    <= k_r;
      asm_r       <= asm_s;

      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end

      case ({wr_accept_s, rd_issue_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase

      case (state_r)
        IDLE: begin
          if (frame_req) begin
            if (enough_s) begin
              stereo_r <= mode_stereo;
              wide_r   <= mode_16bit;
              n_r      <= req_n_s;
              k_r      <= 2'd0;
              state_r  <= FETCH;
            end else begin
              // Not enough data: report immediately with silent samples.
              frame_valid  <= 1'b1;
              underrun     <= 1'b1;
              left_sample  <= 16'h0000;
              right_sample <= 16'h0000;
            end
          end
        end
        FETCH: begin
          if (last_s) begin
            state_r <= DONE;
          end else begin
            k_r <= k_r + 2'd1;
          end
        end
        DONE: begin
          left_sample  <= left_s;
          right_sample <= right_s;
          frame_valid  <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_frame_fifo.sv
// Directed bench for pcm_frame_fifo: byte model plus expected-frame scoreboard.
module tb_pcm_frame_fifo;

  logic        clk;
  logic        rst;
  logic        fifo_reset;
  logic [7:0]  fifo_wrdata;
  logic        fifo_write;
  logic        fifo_full;
  logic        fifo_almost_empty;
  logic        fifo_empty;
  logic        mode_stereo;
  logic        mode_16bit;
  logic        frame_req;
  logic        frame_valid;
  logic        underrun;
  logic [15:0] left_sample;
  logic [15:0] right_sample;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        un;
  } exp_t;

  logic [7:0] mdl_q[$];
  exp_t       exp_q[$];
  int         n_checks;
  int         n_errors;

  pcm_frame_fifo #(.DEPTH_LOG2(12), .AE_THRESHOLD(1024)) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_reset        (fifo_reset),
    .fifo_wrdata       (fifo_wrdata),
    .fifo_write        (fifo_write),
    .fifo_full         (fifo_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_empty        (fifo_empty),
    .mode_stereo       (mode_stereo),
    .mode_16bit        (mode_16bit),
    .frame_req         (frame_req),
    .frame_valid       (frame_valid),
    .underrun          (underrun),
    .left_sample       (left_sample),
    .right_sample      (right_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_empty"}, 32'(fifo_empty), 32'(mdl_q.size() == 0));
    check({tag, "_full"},  32'(fifo_full),  32'(mdl_q.size() == 4096));
    check({tag, "_ae"},    32'(fifo_almost_empty), 32'(mdl_q.size() < 1024));
  endtask

  task automatic write_bytes(input int n, input int mul, input int add);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b           = 8'(i * mul + add);
      fifo_write  = 1'b1;
      fifo_wrdata = b;
      if (mdl_q.size() < 4096) mdl_q.push_back(b);
      step();
    end
    fifo_write = 1'b0;
  endtask

  task automatic do_frame(input logic st, input logic wide);
    int         n;
    int         lat;
    exp_t       e;
    exp_t       got;
    logic [7:0] b [4];
    n = wide ? (st ? 4 : 2) : (st ? 2 : 1);
    if (mdl_q.size() >= n) begin
      for (int k = 0; k < 4; k++) b[k] = (k < n) ? mdl_q.pop_front() : 8'h00;
      if (wide) begin
        e.l = {b[1], b[0]};
        e.r = st ? {b[3], b[2]} : {b[1], b[0]};
      end else begin
        e.l = {b[0], 8'h00};
        e.r = st ? {b[1], 8'h00} : {b[0], 8'h00};
      end
      e.un = 1'b0;
      lat  = n + 2;
    end else begin
      e   = '{16'h0000, 16'h0000, 1'b1};
      lat = 1;
    end
    exp_q.push_back(e);
    mode_stereo = st;
    mode_16bit  = wide;
    frame_req   = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      step();
      frame_req = 1'b0;
      check("frame_valid_timing", 32'(frame_valid), 32'(c == lat));
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(1), 32'(0));
        end else begin
          got = exp_q.pop_front();
          check("left_sample",  32'(left_sample),  32'(got.l));
          check("right_sample", 32'(right_sample), 32'(got.r));
          check("underrun",     32'(underrun),     32'(got.un));
        end
      end
    end
    if (exp_q.size() != 0) begin
      check("frame_missing", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b0;
    fifo_reset  = 1'b0;
    fifo_wrdata = 8'h00;
    fifo_write  = 1'b0;
    mode_stereo = 1'b0;
    mode_16bit  = 1'b0;
    frame_req   = 1'b0;

    // Reset state, during and after reset
    #1;
    check_flags("in_reset");
    check("in_reset_fv", 32'(frame_valid), 32'(0));
    repeat (3) step();
    rst = 1'b1;
    step();
    check_flags("after_reset");
    check("after_reset_left",  32'(left_sample),  32'(0));
    check("after_reset_right", 32'(right_sample), 32'(0));
    check("after_reset_un",    32'(underrun),     32'(0));

    // almost_empty drops once the 1024th byte is counted
    write_bytes(1023, 1, 0);
    check("ae_at_1023", 32'(fifo_almost_empty), 32'(1));
    write_bytes(1, 1, 0);
    check("ae_at_1024", 32'(fifo_almost_empty), 32'(0));
    check_flags("at_1024");

    // Flush overrides a same-cycle write
    fifo_reset  = 1'b1;
    fifo_write  = 1'b1;
    fifo_wrdata = 8'h5A;
    step();
    fifo_reset = 1'b0;
    fifo_write = 1'b0;
    mdl_q.delete();
    check_flags("after_flush");

    // 16-bit stereo, then 8-bit mono
    mdl_q.push_back(8'h34); mdl_q.push_back(8'h12);
    mdl_q.push_back(8'h78); mdl_q.push_back(8'h56);
    fifo_write = 1'b1;
    foreach (mdl_q[i]) begin
      fifo_wrdata = mdl_q[i];
      step();
    end
    fifo_write = 1'b0;
    do_frame(1'b1, 1'b1);
    check("s16_left_const",  32'(left_sample),  32'(16'h1234));
    check("s16_right_const", 32'(right_sample), 32'(16'h5678));
    check_flags("after_s16");
    write_bytes(1, 0, 8'h80);
    do_frame(1'b0, 1'b0);
    check("m8_left_const", 32'(left_sample), 32'(16'h8000));

    // Underrun with 3 bytes; count must remain 3
    write_bytes(3, 17, 3);
    do_frame(1'b1, 1'b1);
    check_flags("after_underrun");
    do_frame(1'b0, 1'b1);
    do_frame(1'b0, 1'b0);
    check_flags("after_drain3");
    write_bytes(2, 29, 200);
    do_frame(1'b1, 1'b0);
    check_flags("after_s8");

    // Fill across the pointer wrap, overfill, drain as 8-bit mono
    write_bytes(4096, 1, 0);
    check_flags("filled");
    write_bytes(1, 0, 8'hAA);
    check_flags("overfill");
    for (int i = 0; i < 4096; i++) do_frame(1'b0, 1'b0);
    check_flags("drained");

    // Refill and drain as 16-bit stereo
    write_bytes(3000, 7, 11);
    check_flags("refilled");
    for (int i = 0; i < 750; i++) do_frame(1'b1, 1'b1);
    check_flags("drained2");

    // Flush in the middle of a fetch
    write_bytes(4, 13, 1);
    mode_stereo = 1'b1;
    mode_16bit  = 1'b1;
    frame_req   = 1'b1;
    step();
    frame_req = 1'b0;
    step();
    fifo_reset = 1'b1;
    step();
    fifo_reset = 1'b0;
    mdl_q.delete();
    check("flush_left",  32'(left_sample),  32'(0));
    check("flush_right", 32'(right_sample), 32'(0));
    check_flags("flush_mid");
    for (int c = 0; c < 6; c++) begin
      check("flush_no_fv", 32'(frame_valid), 32'(0));
      step();
    end
    do_frame(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
